// File: rtl/bsg_cycle_stamp_pkg.sv
// Shared types and helpers for the cycle-stamp event FIFO.
package bsg_cycle_stamp_pkg;

    localparam int unsigned default_width_lp     = 16;
    localparam int unsigned default_tag_width_lp = 4;
    localparam int unsigned default_els_lp       = 4;

    // log2 of the FIFO depth; pointers carry one extra wrap bit on top of this
    function automatic int unsigned lg_els(input int unsigned els);
        return $clog2(els);
    endfunction

    localparam int unsigned default_lg_els_lp = $clog2(default_els_lp);

    // FIFO entry at the default widths; data_o is laid out as {tag, stamp}
    typedef struct packed {
        logic [default_tag_width_lp-1:0] tag;
        logic [default_width_lp-1:0]     stamp;
    } entry_s;

endpackage

// File: rtl/bsg_cycle_stamp_mem.sv
// 1R1W register file: synchronous write, asynchronous read.
module bsg_cycle_stamp_mem #(
    parameter int unsigned els_p   = 4,
    parameter int unsigned width_p = 20,
    parameter int unsigned addr_w_p = 2
) (
    input  logic                clk_i,
    input  logic                w_v_i,
    input  logic [addr_w_p-1:0] w_addr_i,
    input  logic [width_p-1:0]  w_data_i,
    input  logic [addr_w_p-1:0] r_addr_i,
    output logic [width_p-1:0]  r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // write port; storage needs no reset since the top masks data while empty
    always_ff @(posedge clk_i) begin
        if (w_v_i) mem_r[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bsg_cycle_stamp_fifo.sv
// Event timestamp FIFO: stamps accepted events with the cycle counter,
// counts (saturating) events that arrive while full.
// Optional macro BSG_CYCLE_STAMP_DELTA_EN: stamp is the delta since the
// previous accepted event instead of the absolute counter value.
module bsg_cycle_stamp_fifo
    import bsg_cycle_stamp_pkg::*;
#(
    parameter int unsigned width_p      = 16,
    parameter int unsigned tag_width_p  = 4,
    parameter int unsigned els_p        = 4,
    parameter int unsigned drop_width_p = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [width_p-1:0]             ctr_i,
    input  logic                           event_v_i,
    input  logic [tag_width_p-1:0]         event_tag_i,
    output logic                           v_o,
    output logic [tag_width_p+width_p-1:0] data_o,
    input  logic                           yumi_i,
    input  logic                           clear_i,
    output logic [drop_width_p-1:0]        drop_cnt_o,
    output logic                           overflow_o
);

    localparam int unsigned lg_lp  = lg_els(els_p);
    localparam int unsigned ptr_lp = lg_lp + 1;

    typedef struct packed {
        logic [tag_width_p-1:0] tag;
        logic [width_p-1:0]     stamp;
    } entry_t;

    logic [ptr_lp-1:0]       wptr_r, rptr_r;
    logic [drop_width_p-1:0] drop_cnt_r;
    logic                    overflow_r;
    logic                    full, empty, deq, enq, drop;
    logic [width_p-1:0]      stamp;
    entry_t                  wr_entry, rd_entry;

    assign empty = (wptr_r == rptr_r);
    assign full  = (wptr_r[lg_lp] != rptr_r[lg_lp])
                && (wptr_r[lg_lp-1:0] == rptr_r[lg_lp-1:0]);

    // an illegal yumi while empty is ignored so state stays consistent
    assign deq  = yumi_i & ~empty;
    assign enq  = event_v_i & (~full | deq);
    assign drop = event_v_i & full & ~deq;

`ifdef BSG_CYCLE_STAMP_DELTA_EN
    logic [width_p-1:0] last_r;

    // remember the counter of the last accepted event; drops leave it alone
    always_ff @(posedge clk_i) begin
        if (reset_i)  last_r <= '0;
        else if (enq) last_r <= ctr_i;
    end

    assign stamp = ctr_i - last_r;
`else
    assign stamp = ctr_i;
`endif

    assign wr_entry = '{tag: event_tag_i, stamp: stamp};

    // read/write pointers with a wrap bit to tell full from empty
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (enq) wptr_r <= wptr_r + ptr_lp'(1);
            if (deq) rptr_r <= rptr_r + ptr_lp'(1);
        end
    end

    // saturating drop counter and sticky overflow; a drop wins over clear
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drop_cnt_r <= '0;
            overflow_r <= 1'b0;
        end else if (clear_i) begin
            drop_cnt_r <= drop ? drop_width_p'(1) : '0;
            overflow_r <= drop;
        end else if (drop) begin
            if (~&drop_cnt_r) drop_cnt_r <= drop_cnt_r + drop_width_p'(1);
            overflow_r <= 1'b1;
        end
    end

    bsg_cycle_stamp_mem #(
        .els_p    (els_p),
        .width_p  (tag_width_p + width_p),
        .addr_w_p (lg_lp)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (enq),
        .w_addr_i (wptr_r[lg_lp-1:0]),
        .w_data_i (wr_entry),
        .r_addr_i (rptr_r[lg_lp-1:0]),
        .r_data_o (rd_entry)
    );

    assign v_o        = ~empty;
    assign data_o     = v_o ? rd_entry : '0;
    assign drop_cnt_o = drop_cnt_r;
    assign overflow_o = overflow_r;

    yumi_when_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_cycle_stamp_fifo.sv
// Directed bench for bsg_cycle_stamp_fifo (width 16, tag 4, depth 4, drop 8).
// Build with BSG_CYCLE_STAMP_DELTA_EN to check the delta-stamp variant.
module tb_bsg_cycle_stamp_fifo;
    import bsg_cycle_stamp_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [15:0] ctr_i = '0;
    logic        event_v_i = 1'b0;
    logic [3:0]  event_tag_i = '0;
    logic        v_o;
    logic [19:0] data_o;
    logic        yumi_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [7:0]  drop_cnt_o;
    logic        overflow_o;

    int vectors = 0;
    int miscompares = 0;

    bsg_cycle_stamp_fifo #(
        .width_p(16), .tag_width_p(4), .els_p(4), .drop_width_p(8)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ctr_i       (ctr_i),
        .event_v_i   (event_v_i),
        .event_tag_i (event_tag_i),
        .v_o         (v_o),
        .data_o      (data_o),
        .yumi_i      (yumi_i),
        .clear_i     (clear_i),
        .drop_cnt_o  (drop_cnt_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef BSG_CYCLE_STAMP_DELTA_EN
    localparam bit delta = 1'b1;
`else
    localparam bit delta = 1'b0;
`endif

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic [3:0] t, input logic [15:0] s);
        entry_s e;
        e = '{tag: t, stamp: s};
        return 32'(e);
    endfunction

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    task automatic ev(input logic [3:0] t, input logic [15:0] c, input logic y);
        event_v_i = 1'b1; event_tag_i = t; ctr_i = c; yumi_i = y;
        tick();
        event_v_i = 1'b0; yumi_i = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [3:0] t, input logic [15:0] s);
        chk({tag, "_v"}, 32'(v_o), 32'd1);
        chk(tag, 32'(data_o), ent(t, s));
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        tick();
        chk("rst_v", 32'(v_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_drop", 32'(drop_cnt_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);

        // single event, visible next cycle, then consumed
        ev(4'd3, 16'h0010, 1'b0);
        pop_chk("single", 4'd3, 16'h0010);
        chk("single_empty_v", 32'(v_o), 32'd0);
        chk("single_empty_data", 32'(data_o), 32'd0);

        // fill to full, drop the fifth, drain in order
        for (int i = 0; i < 4; i++) ev(4'(i + 1), 16'h0020 + 16'(i), 1'b0);
        ev(4'd5, 16'h0024, 1'b0);
        chk("fill_drop", 32'(drop_cnt_o), 32'd1);
        chk("fill_ovf", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 4; i++)
            pop_chk("fill_drain", 4'(i + 1),
                    delta ? (i == 0 ? 16'h0010 : 16'h0001) : 16'h0020 + 16'(i));
        chk("fill_empty", 32'(v_o), 32'd0);

        // full with simultaneous enqueue + dequeue
        for (int i = 0; i < 4; i++) ev(4'(i + 6), 16'h0030 + 16'(i), 1'b0);
        ev(4'hA, 16'h0040, 1'b1);
        chk("simul_drop", 32'(drop_cnt_o), 32'd1);
        for (int i = 0; i < 3; i++)
            pop_chk("simul_drain", 4'(i + 7), delta ? 16'h0001 : 16'h0031 + 16'(i));
        pop_chk("simul_last", 4'hA, delta ? 16'h000D : 16'h0040);
        chk("simul_empty", 32'(v_o), 32'd0);

        // drop counter saturation and clear behaviour
        for (int i = 0; i < 4; i++) ev(4'd0, 16'h0050 + 16'(i), 1'b0);
        event_v_i = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        event_v_i = 1'b0;
        chk("sat_drop", 32'(drop_cnt_o), 32'hFF);
        chk("sat_ovf", 32'(overflow_o), 32'd1);
        clear_i = 1'b1; tick(); clear_i = 1'b0;
        chk("clr_drop", 32'(drop_cnt_o), 32'd0);
        chk("clr_ovf", 32'(overflow_o), 32'd0);
        clear_i = 1'b1; ev(4'd0, 16'h0060, 1'b0); clear_i = 1'b0;
        chk("clr_with_drop", 32'(drop_cnt_o), 32'd1);
        chk("clr_with_drop_ovf", 32'(overflow_o), 32'd1);
        chk("still_full_v", 32'(v_o), 32'd1);

        // counter wrap, from a fresh reset
        do_reset();
        ev(4'd1, 16'hFFFE, 1'b0);
        ev(4'd2, 16'h0002, 1'b0);
        pop_chk("wrap0", 4'd1, 16'hFFFE);
        pop_chk("wrap1", 4'd2, delta ? 16'h0004 : 16'h0002);

        // reset with three entries queued and a nonzero drop count
        for (int i = 0; i < 4; i++) ev(4'd4, 16'h0100 + 16'(i), 1'b0);
        ev(4'd4, 16'h0104, 1'b0);
        yumi_i = 1'b1; tick(); yumi_i = 1'b0;
        chk("pre_rst_drop", 32'(drop_cnt_o), 32'd1);
        do_reset();
        chk("mid_rst_v", 32'(v_o), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt_o), 32'd0);
        chk("mid_rst_ovf", 32'(overflow_o), 32'd0);
        chk("mid_rst_data", 32'(data_o), 32'd0);
        ev(4'd5, 16'h0200, 1'b0);
        pop_chk("post_rst", 4'd5, 16'h0200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
